// File: rtl/vdiv_iter.sv
// vdiv_iter -- iterative IEEE-754 binary16 divider (quotient = A / B).
//
// Purpose:
//   Multi-cycle divider built around a restoring division datapath. A
//   request is captured in IDLE, then the operation walks through
//   PREP -> (NORM) -> DIV -> ROUND -> DONE. Exponent 31 is treated as an
//   ordinary finite exponent and subnormal inputs are normalized in NORM.
//   Results never come out subnormal: tiny results flush to signed zero.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   request, only looked at in IDLE
//   A          in  16   dividend (binary16)
//   B          in  16   divisor  (binary16)
//   quotient   out 16   registered result, held until the next accepted start
//   busy       out  1   high in every state except IDLE
//   done       out  1   one-cycle pulse while the result is valid
//   Overflow   out  1   result exponent above 30, quotient forced to signed Inf pattern
//   Underflow  out  1   result exponent below 1, quotient forced to signed zero
//   DivByZero  out  1   divisor magnitude zero, quotient forced to signed Inf pattern

module vdiv_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] quotient,
    output logic        busy,
    output logic        done,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        NORM,
        DIV,
        ROUND,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        opA_q, opA_d;
    logic [15:0]        opB_q, opB_d;
    logic               sign_q, sign_d;
    logic signed [7:0]  exp_q, exp_d;
    logic [10:0]        mantA_q, mantA_d;
    logic [10:0]        mantB_q, mantB_d;
    logic [11:0]        rem_q, rem_d;
    logic [13:0]        quo_q, quo_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               dbz_q, dbz_d;

    // Operand unpacking used by PREP. A zero exponent field means a
    // subnormal: hidden bit 0 and an effective exponent of 1.
    logic [4:0]         expA, expB;
    logic [10:0]        sigA, sigB;
    logic signed [7:0]  expPrep;
    logic               signPrep;

    // NORM step values, DIV step values and ROUND values.
    logic [10:0]        shiftA, shiftB;
    logic signed [7:0]  expNorm;
    logic               divGe;
    logic [11:0]        divRem;
    logic [10:0]        roundMant;
    logic               roundR, roundS, roundUp;
    logic [11:0]        roundInc;
    logic [10:0]        finalMant;
    logic signed [7:0]  roundExp;

    // Combinational helpers for each phase, evaluated every cycle and
    // consumed by the next-state logic only in the matching state.
    always_comb begin
        expA     = (opA_q[14:10] == 5'd0) ? 5'd1 : opA_q[14:10];
        expB     = (opB_q[14:10] == 5'd0) ? 5'd1 : opB_q[14:10];
        sigA     = {(opA_q[14:10] != 5'd0), opA_q[9:0]};
        sigB     = {(opB_q[14:10] != 5'd0), opB_q[9:0]};
        expPrep  = $signed({3'b000, expA}) - $signed({3'b000, expB}) + 8'sd15;
        signPrep = opA_q[15] ^ opB_q[15];

        // A dividend shift lowers the exponent, a divisor shift raises it;
        // both can happen in the same cycle.
        shiftA  = mantA_q[10] ? mantA_q : (mantA_q << 1);
        shiftB  = mantB_q[10] ? mantB_q : (mantB_q << 1);
        expNorm = exp_q;
        if (!mantA_q[10]) begin
            expNorm = expNorm - 8'sd1;
        end
        if (!mantB_q[10]) begin
            expNorm = expNorm + 8'sd1;
        end

        // Restoring division step. The partial remainder always stays
        // below twice the divisor, so 12 bits are enough.
        divGe  = (rem_q >= {1'b0, mantB_q});
        divRem = divGe ? (rem_q - {1'b0, mantB_q}) : rem_q;

        // With both significands normalized the raw quotient lies in
        // (0.5, 2), so q[12] is set whenever the integer bit q[13] is not.
        if (quo_q[13]) begin
            roundMant = quo_q[13:3];
            roundR    = quo_q[2];
            roundS    = (|quo_q[1:0]) | (|rem_q);
            roundExp  = exp_q;
        end else begin
            roundMant = quo_q[12:2];
            roundR    = quo_q[1];
            roundS    = quo_q[0] | (|rem_q);
            roundExp  = exp_q - 8'sd1;
        end
        roundUp  = roundR & (roundS | roundMant[0]);
        roundInc = {1'b0, roundMant} + {11'd0, roundUp};
        if (roundInc[11]) begin
            finalMant = roundInc[11:1];
            roundExp  = roundExp + 8'sd1;
        end else begin
            finalMant = roundInc[10:0];
        end
    end

    // Next-state and datapath next values. Everything holds by default;
    // each state only overrides what it advances.
    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mantA_d  = mantA_q;
        mantB_d  = mantB_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opA_d   = A;
                    opB_d   = B;
                    state_d = PREP;
                end
            end

            PREP: begin
                sign_d  = signPrep;
                exp_d   = expPrep;
                mantA_d = sigA;
                mantB_d = sigB;
                rem_d   = {1'b0, sigA};
                quo_d   = 14'd0;
                cnt_d   = 4'd0;
                // A zero divisor wins over a zero dividend.
                if (opB_q[14:0] == 15'd0) begin
                    result_d = {signPrep, 5'h1F, 10'h000};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    dbz_d    = 1'b1;
                    state_d  = DONE;
                end else if (opA_q[14:0] == 15'd0) begin
                    result_d = {signPrep, 15'h0000};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    dbz_d    = 1'b0;
                    state_d  = DONE;
                end else if (sigA[10] && sigB[10]) begin
                    state_d = DIV;
                end else begin
                    state_d = NORM;
                end
            end

            NORM: begin
                mantA_d = shiftA;
                mantB_d = shiftB;
                exp_d   = expNorm;
                rem_d   = {1'b0, shiftA};
                if (shiftA[10] && shiftB[10]) begin
                    state_d = DIV;
                end
            end

            DIV: begin
                quo_d = {quo_q[12:0], divGe};
                rem_d = {divRem[10:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                if (roundExp > 8'sd30) begin
                    result_d = {sign_q, 5'h1F, 10'h000};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                end else if (roundExp < 8'sd1) begin
                    result_d = {sign_q, 15'h0000};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, roundExp[4:0], finalMant[9:0]};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                end
                dbz_d   = 1'b0;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so the outputs
    // read zero while rst_n is low, independent of the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opA_q    <= 16'd0;
            opB_q    <= 16'd0;
            sign_q   <= 1'b0;
            exp_q    <= 8'sd0;
            mantA_q  <= 11'd0;
            mantB_q  <= 11'd0;
            rem_q    <= 12'd0;
            quo_q    <= 14'd0;
            cnt_q    <= 4'd0;
            result_q <= 16'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mantA_q  <= mantA_d;
            mantB_q  <= mantB_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign quotient  = result_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign DivByZero = dbz_q;

endmodule

// File: doc/vdiv_iter.md
VDIV_ITER -- requirements
Module: vdiv_iter

Interface
REQ-001 The block SHALL have no parameters; the format is fixed at IEEE-754 binary16 (1 sign, 5 exponent bias 15, 10 fraction).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; SHALL be sampled only in IDLE.
REQ-005 A  input  16  dividend, binary16.
REQ-006 B  input  16  divisor, binary16.
REQ-007 quotient  output  16  A/B result; SHALL be registered and held from done until the next accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when quotient and flags are valid.
REQ-010 Overflow, Underflow, DivByZero  output  1 each  result flags; SHALL be registered and held like quotient.

Function
REQ-011 The FSM states SHALL be IDLE, PREP, NORM, DIV, ROUND and DONE; DONE SHALL always return to IDLE after one cycle.
REQ-012 On start=1 in IDLE, the block SHALL capture A and B and go to PREP; start SHALL be ignored in all other states.
REQ-013 PREP SHALL compute sign = A[15]^B[15] and set the hidden bit to 1 for exponent != 0, or to 0 with effective exponent 1 for exponent = 0.
REQ-014 PREP SHALL form the signed 8-bit exponent e = eA - eB + 15.
REQ-015 Exponent 31 SHALL be treated as an ordinary finite exponent; no Inf or NaN decoding is performed.
REQ-016 Special case, B magnitude zero: PREP -> DONE with quotient {sign,5'h1F,10'h0}, DivByZero=1, Overflow=0, Underflow=0; this takes priority over A=0.
REQ-017 Special case, A magnitude zero and B nonzero: PREP -> DONE with quotient {sign,15'h0} and all flags 0.
REQ-018 NORM SHALL left-shift each unnormalized 11-bit significand by one bit per cycle until bit 10 is set.
REQ-019 Each NORM shift SHALL decrement e for a dividend shift and increment e for a divisor shift; both operands may shift in the same cycle.
REQ-020 NORM SHALL be skipped, PREP -> DIV, when both significands are already normalized.
REQ-021 DIV SHALL perform restoring division for exactly 14 cycles, one quotient bit per cycle, MSB first, giving q[13:0] with q[13] the integer bit.
REQ-022 DIV SHALL produce a final remainder rem; sticky includes (rem != 0).
REQ-023 ROUND, case q[13]=1: mantissa = q[13:3], round bit R = q[2], sticky S = |q[1:0] | (rem != 0).
REQ-024 ROUND, case q[13]=0: mantissa = q[12:2], R = q[1], S = q[0] | (rem != 0), and e = e - 1.
REQ-025 ROUND SHALL round to nearest even: increment mantissa when R & (S | mantissa[0]).
REQ-026 A rounding carry-out of mantissa SHALL shift the mantissa right by one and increment e.
REQ-027 Overflow: if e > 30 after rounding, quotient = {sign,5'h1F,10'h0} and Overflow=1.
REQ-028 Underflow: if e < 1 after rounding, quotient = {sign,15'h0} and Underflow=1; no subnormal results are produced.
REQ-029 Otherwise quotient = {sign, e[4:0], mantissa[9:0]} with all flags 0.
REQ-030 done SHALL be high only in DONE; quotient and flags SHALL update on the edge entering DONE.
REQ-031 Latency: with start high at cycle N, done SHALL be high at cycle N+17+k, where k is the NORM cycle count (max leading zeros of the two significands).
REQ-032 Latency for special cases (REQ-016, REQ-017): done SHALL be high at cycle N+2.
REQ-033 A new start SHALL be accepted in the IDLE cycle immediately after DONE, giving back-to-back throughput.

Reset
REQ-034 While rst_n=0, state SHALL be IDLE and quotient, busy, done, Overflow, Underflow and DivByZero SHALL be 0, regardless of clk.
REQ-035 A reset asserted mid-operation SHALL abort the operation; no done pulse occurs, and after release the block SHALL accept a fresh start.

Verification
REQ-036 A=0x3C00, B=0x3C00, start at N -> done at N+17, quotient=0x3C00, flags 0.
REQ-037 Rounding and normalization: 0x4200/0x4000 -> 0x3E00; 0x3C00/0x4200 -> 0x3555 (RNE); all flags 0.
REQ-038 Subnormal dividend: 0x0200/0x0400 -> 0x3800 with done at N+18 (k=1).
REQ-039 Flags: 0x3C00/0x0000 -> 0x7C00, DivByZero=1, done at N+2; 0x7BFF/0x0001 -> 0x7C00, Overflow=1; 0x8001/0x7BFF -> 0x8000, Underflow=1.
REQ-040 Busy and reset: start pulsed again while busy is ignored; rst_n low during DIV -> all outputs 0 immediately and no done pulse; a subsequent 0x3C00/0x3C00 completes normally.
